// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared record kinds, FSM states and record layout for the tv80 bus monitor
package z80_bus_pkg;
    typedef enum logic [2:0] {
        K_OPFETCH = 3'd0,
        K_MEMRD   = 3'd1,
        K_MEMWR   = 3'd2,
        K_IORD    = 3'd3,
        K_IOWR    = 3'd4,
        K_INTACK  = 3'd5,
        K_REFRESH = 3'd6,
        K_NONE    = 3'd7
    } kind_e;

    typedef enum logic {S_IDLE, S_ACTIVE} state_e;

    localparam int REC_TS_W = 16;

    typedef struct packed {
        kind_e                kind;
        logic [15:0]          addr;
        logic [7:0]           data;
        logic [REC_TS_W-1:0]  ts;
    } rec_t;

    function automatic logic is_read_kind(input kind_e k);
        return k inside {K_OPFETCH, K_MEMRD, K_IORD, K_INTACK};
    endfunction
endpackage

// File: rtl/z80_bus_fifo.sv
// z80_bus_fifo: synchronous power-of-two FIFO of bus records; push is accepted when full if a pop happens in the same cycle
module z80_bus_fifo import z80_bus_pkg::*; #(
    parameter int  DEPTH = 16,
    parameter type T     = rec_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [AW:0]    cnt;
    logic           do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign dout    = mem[rp];

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            if (do_push != do_pop) cnt <= do_push ? cnt + 1'b1 : cnt - 1'b1;
        end
    end
endmodule

// File: rtl/z80_bus_monitor.sv
// z80_bus_monitor: classifies tv80 bus strobes into one timestamped record per machine cycle
// and queues the records behind a valid/ready FIFO with sticky overflow accounting.
module z80_bus_monitor import z80_bus_pkg::*; #(
    parameter int DEPTH   = 16,
    parameter int TS_W    = 16,
    parameter int EN_RFSH = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m1_n,
    input  logic            mreq_n,
    input  logic            iorq_n,
    input  logic            rd_n,
    input  logic            wr_n,
    input  logic            rfsh_n,
    input  logic [15:0]     A,
    input  logic [7:0]      di,
    input  logic [7:0]      dout,
    input  logic            clear,
    output logic            rec_valid,
    input  logic            rec_ready,
    output logic [2:0]      rec_kind,
    output logic [15:0]     rec_addr,
    output logic [7:0]      rec_data,
    output logic [TS_W-1:0] rec_ts,
    output logic            overflow,
    output logic [7:0]      drop_cnt
);
    typedef struct packed {
        kind_e            kind;
        logic [15:0]      addr;
        logic [7:0]       data;
        logic [TS_W-1:0]  ts;
    } trec_t;

    logic            m1, mreq, iorq, rd, wr, rfsh;
    kind_e           q_kind, cur_kind;
    logic [7:0]      q_data, cur_data;
    logic [15:0]     cur_addr;
    logic [TS_W-1:0] cur_ts, ts_cnt;
    state_e          state, next;
    logic            hold, emit, load, push, pop, drop, full, empty;
    trec_t           tail, head;

    // X/Z fails the === test, so an undriven strobe reads as inactive
    assign m1   = m1_n === 1'b0;
    assign mreq = mreq_n === 1'b0;
    assign iorq = iorq_n === 1'b0;
    assign rd   = rd_n === 1'b0;
    assign wr   = wr_n === 1'b0;
    assign rfsh = rfsh_n === 1'b0;

    always_comb begin
        q_kind = (m1 && iorq)                         ? K_INTACK  :
                 (m1 && mreq && rd)                   ? K_OPFETCH :
                 (EN_RFSH != 0 && rfsh && mreq)       ? K_REFRESH :
                 (iorq && rd)                         ? K_IORD    :
                 (iorq && wr)                         ? K_IOWR    :
                 (mreq && rd)                         ? K_MEMRD   :
                 (mreq && wr)                         ? K_MEMWR   : K_NONE;
        q_data = is_read_kind(q_kind) ? di : (q_kind == K_REFRESH) ? 8'h00 : dout;
    end

    // A kind change both closes the current record and, unless NONE, opens the next one
    always_comb begin
        hold = state == S_ACTIVE && q_kind == cur_kind;
        emit = state == S_ACTIVE && q_kind != cur_kind;
        load = q_kind != K_NONE && !hold;
        next = q_kind != K_NONE ? S_ACTIVE : S_IDLE;
    end

    always_ff @(posedge clk)
        state <= reset ? S_IDLE : next;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt   <= '0;
            cur_kind <= K_NONE;
            cur_addr <= '0;
            cur_data <= '0;
            cur_ts   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (load || hold) cur_data <= q_data;
            if (load) begin
                cur_kind <= q_kind;
                cur_addr <= A;
                cur_ts   <= ts_cnt;
            end
            if (clear) begin
                overflow <= drop;
                drop_cnt <= {7'd0, drop};
            end else if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= drop_cnt + {7'd0, drop_cnt != 8'hFF};
            end
        end
    end

    assign pop  = !empty && rec_ready;
    assign push = emit && (!full || pop);
    assign drop = emit && full && !pop;
    assign tail = '{kind: cur_kind, addr: cur_addr, data: cur_data, ts: cur_ts};

    z80_bus_fifo #(.DEPTH(DEPTH), .T(trec_t)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (tail),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign rec_valid = !empty;
    assign rec_kind  = rec_valid ? head.kind : 3'd0;
    assign rec_addr  = rec_valid ? head.addr : 16'h0000;
    assign rec_data  = rec_valid ? head.data : 8'h00;
    assign rec_ts    = rec_valid ? head.ts : '0;
endmodule
